// File: rtl/mem_stage.sv
// Pipeline MEM stage: drives the data bus for loads/stores, sequences each access
// with an IDLE/WAITING/OVER FSM, and produces the MEM/WB record plus a forwarding record.
package mem_stage_pkg;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;      // 0=B, 1=H, 2=W, 3=D
    logic       mem_unsigned;
  } ctl_t;

  typedef struct packed {
    ctl_t        ctl;
    logic [63:0] rd;
    logic [63:0] aluout;
    logic [4:0]  dst;
    logic [31:0] instr;
    logic [63:0] pcjump;
  } exec_data_t;

  typedef struct packed {
    ctl_t        ctl;
    logic [63:0] writedata;
    logic [4:0]  dst;
    logic [31:0] instr;
  } mem_data_t;

  typedef struct packed {
    logic [4:0]  dst;
    logic [63:0] data;
    logic        valid;
  } fwd_data_t;

  typedef enum logic [1:0] {S_IDLE, S_WAITING, S_OVER} mem_access_state_t;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned BUS_LATENCY_MAX = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  exec_data_t  in,
  output logic        out_valid,
  output mem_data_t   out,
  output fwd_data_t   fwd,
  output logic        stall,
  output logic        err,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data
);

  mem_access_state_t r_state, w_state_next;
  logic        r_addr_ok;
  logic [63:0] r_load_word;

  logic        w_mem_op;
  logic [2:0]  w_align_mask;
  logic [2:0]  w_off;
  logic [5:0]  w_shamt;
  logic [7:0]  w_strobe_base;
  logic [63:0] w_load_shifted;
  logic [63:0] w_load_ext;
  logic [63:0] w_writedata;
  logic        w_dreq_valid;
  logic        w_stall;
  logic        w_out_valid;
  logic        w_unused;

  assign w_unused = ^in.pcjump;
  assign w_mem_op = in_valid & (in.ctl.mem_read | in.ctl.mem_write);

  // Offset is aligned down to the access size; sub-size address bits are ignored.
  always_comb begin
    w_align_mask  = 3'b111;
    w_strobe_base = 8'h01;
    case (in.ctl.mem_size)
      2'd0: begin w_align_mask = 3'b111; w_strobe_base = 8'h01; end
      2'd1: begin w_align_mask = 3'b110; w_strobe_base = 8'h03; end
      2'd2: begin w_align_mask = 3'b100; w_strobe_base = 8'h0F; end
      default: begin w_align_mask = 3'b000; w_strobe_base = 8'hFF; end
    endcase
  end

  assign w_off       = in.aluout[2:0] & w_align_mask;
  assign w_shamt     = {w_off, 3'b000};
  assign dreq_addr   = {in.aluout[63:3], w_off};
  assign dreq_size   = {1'b0, in.ctl.mem_size};
  assign dreq_data   = in.rd << w_shamt;
  assign dreq_strobe = in.ctl.mem_write ? (w_strobe_base << w_off) : 8'h00;

  assign w_load_shifted = r_load_word >> w_shamt;

  always_comb begin
    w_load_ext = w_load_shifted;
    case (in.ctl.mem_size)
      2'd0: w_load_ext = in.ctl.mem_unsigned ? {56'd0, w_load_shifted[7:0]}
                                             : {{56{w_load_shifted[7]}}, w_load_shifted[7:0]};
      2'd1: w_load_ext = in.ctl.mem_unsigned ? {48'd0, w_load_shifted[15:0]}
                                             : {{48{w_load_shifted[15]}}, w_load_shifted[15:0]};
      2'd2: w_load_ext = in.ctl.mem_unsigned ? {32'd0, w_load_shifted[31:0]}
                                             : {{32{w_load_shifted[31]}}, w_load_shifted[31:0]};
      default: w_load_ext = w_load_shifted;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_dreq_valid = 1'b0;
    w_stall      = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op) begin
          w_state_next = S_WAITING;
          w_dreq_valid = 1'b1;
          w_stall      = 1'b1;
        end else begin
          w_out_valid  = in_valid;
        end
      end
      S_WAITING: begin
        w_dreq_valid = ~r_addr_ok;
        w_stall      = 1'b1;
        if (dresp_data_ok) w_state_next = S_OVER;
      end
      S_OVER: begin
        w_out_valid  = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_addr_ok   <= 1'b0;
      r_load_word <= 64'd0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != S_WAITING) begin
        r_addr_ok <= 1'b0;
      end else if (w_dreq_valid && dresp_addr_ok) begin
        r_addr_ok <= 1'b1;
      end
      if (r_state == S_WAITING && dresp_data_ok) r_load_word <= dresp_data;
    end
  end

  // Outputs are forced quiet while reset is held, even with a live input.
  assign dreq_valid = reset & w_dreq_valid;
  assign stall      = reset & w_stall;
  assign out_valid  = reset & w_out_valid;

  assign w_writedata = (r_state == S_IDLE) ? in.aluout
                     : (in.ctl.mem_read ? w_load_ext : 64'd0);
  assign out = {in.ctl, w_writedata, in.dst, in.instr};
  assign fwd = {out.dst, out.writedata, out_valid & out.ctl.reg_write & (out.dst != 5'd0)};

  generate
    if (BUS_LATENCY_MAX != 0) begin : g_wd
      localparam int CW = $clog2(BUS_LATENCY_MAX + 1);
      logic [CW-1:0] r_wd_cnt;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_wd_cnt <= '0;
        end else if (r_state == S_WAITING) begin
          if (r_wd_cnt != CW'(BUS_LATENCY_MAX)) r_wd_cnt <= r_wd_cnt + 1'b1;
        end else begin
          r_wd_cnt <= '0;
        end
      end

      // Saturating count means the match below fires exactly once per access.
      assign err = reset & (r_state == S_WAITING) & (r_wd_cnt == CW'(BUS_LATENCY_MAX - 1));
    end else begin : g_no_wd
      assign err = 1'b0;
    end
  endgenerate

endmodule
